uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
//
// PURPOSE
//   Transmit sequencer for the UART core.
//   - Accepts data words over a valid/ready handshake and generates the baud timing.
//   - Serialises each word as an 8N1-style frame on txd_o (LSB first), with optional parity.
//   - Drives busy_o, which feeds the busy_o status of uart_core.
//
// PARAMETERS
//   DIV_WIDTH   16  width of baud divider input
//   DATA_WIDTH  8   data bits per frame (5..9)
//   STOP_BITS   1   stop bits per frame (1 or 2)
//
// PORTS
//   main_clk_i     in   1           clock; all logic on rising edge
//   main_rst_i     in   1           synchronous reset, active-high
//   baud_div_i     in   DIV_WIDTH   bit period minus one, in clock cycles
//   tx_data_i      in   DATA_WIDTH  word to transmit
//   tx_valid_i     in   1           tx_data_i valid
//   tx_ready_o     out  1           controller can accept a word
//   txd_o          out  1           serial output, idle high
//   busy_o         out  1           frame in progress
//   done_o         out  1           1-cycle pulse at end of frame
//   parity_odd_i   in   1           0=even, 1=odd (only with UART_TX_PARITY_EN)
//
// BEHAVIOUR
//   - Reset values: txd_o=1, busy_o=0, done_o=0.
//     FSM resets to IDLE, so tx_ready_o=1 on the first cycle after reset.
//   - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept: tx_valid_i & tx_ready_o in cycle N.
//     - Captures tx_data_i and baud_div_i.
//     - State is START from cycle N+1; txd_o=0 from N+1.
//   - Bit timing: baud counter runs 0..div_q, where div_q is the captured baud_div_i.
//     - tick when counter==div_q; counter then wraps to 0.
//     - Each bit lasts div_q+1 cycles; div_q=0 gives 1 cycle/bit.
//     - A baud_div_i change mid-frame has no effect until the next accept.
//   - DATA: shifts out DATA_WIDTH bits LSB first; bit index counter advances on tick.
//   - STOP: txd_o=1 for STOP_BITS bit periods.
//   - Frame length: (1+DATA_WIDTH+P+STOP_BITS)*(div_q+1) cycles, P=1 with parity else 0.
//   - done_o: pulses in the last cycle of the final stop bit (tick & last stop bit).
//   - tx_ready_o = IDLE | (STOP & tick & last stop bit).
//     - Back-to-back frames have no idle gap: an accept in the done_o cycle goes directly to START.
//     - Without a new accept in that cycle, the FSM returns to IDLE; txd_o stays 1.
//   - busy_o=1 in every state except IDLE. It also stays 1 across a back-to-back transition.
//   - tx_valid_i while not ready: ignored. The word is not captured; no error flag.
//   - Reset asserted mid-frame: on the next edge the FSM goes to IDLE and txd_o=1 (frame truncated).
//     - Counters clear; done_o is not pulsed.
//
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//   - parity_odd_i port present.
//   - PARITY state is inserted after DATA for one bit period.
//   - txd_o = ^data_q ^ parity_odd_i.
//   UART_TX_PARITY_EN undefined:
//   - No parity_odd_i port and no PARITY state; DATA goes directly to STOP.
//
// TESTING
//   1. Reset, baud_div=3, accept 0xA5 at cycle 0.
//      -> txd_o from cycle 1: bit values 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
//      -> done_o pulse at cycle 40; busy_o=1 over cycles 1..40.
//   2. Hold tx_valid high with 0x01 then 0xFF, baud_div=0.
//      -> Second start bit directly follows the first frame's stop bit; tx_ready_o high only in IDLE/done cycles.
//      -> 20 consecutive busy cycles.
//   3. PARITY_EN, parity_odd=0, data 0x07, baud_div=1.
//      -> Parity bit=1 for 2 cycles, between data bit 7 and the stop bit.
//      -> Odd parity gives 0.
//   4. Assert main_rst_i at data bit 3 of a frame.
//      -> Next cycle txd_o=1, busy_o=0, no done_o.
//      -> tx_ready_o=1 once reset is released.
//   5. Change baud_div 3->9 mid-frame.
//      -> Current frame keeps 4-cycle bits; the next frame uses 10-cycle bits.
//   6. STOP_BITS=2, baud_div=2.
//      -> Stop phase lasts 6 cycles; done_o in its final cycle.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: valid/ready word intake, baud timing, and 8N1-style serialisation, LSB first.
// Define UART_TX_PARITY_EN to add the parity_odd_i port and a parity bit after the data bits.
module uart_tx_ctrl #(
    parameter int DIV_WIDTH  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  main_clk_i,
    input  logic                  main_rst_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  txd_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef UART_TX_PARITY_EN
    ,
    input  logic                  parity_odd_i
`endif
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [BW-1:0]         bit_q;
    logic                  stop_q;
    logic                  txd_q;
`ifdef UART_TX_PARITY_EN
    logic [DATA_WIDTH-1:0] data_q;
`endif

    logic tick, last_stop, accept;

    assign tick       = (cnt_q == div_q);
    assign last_stop  = (state_q == STOP) && tick && (stop_q == STOP_LAST);
    assign tx_ready_o = (state_q == IDLE) || last_stop;
    assign accept     = tx_valid_i && tx_ready_o;
    assign done_o     = last_stop;
    assign busy_o     = (state_q != IDLE);
    assign txd_o      = txd_q;

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            data_q  <= '0;
`endif
        end else if (accept) begin
            // An accept on the final stop tick chains straight into the next start bit.
            state_q <= START;
            cnt_q   <= '0;
            div_q   <= baud_div_i;
            sh_q    <= tx_data_i;
            txd_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            data_q  <= tx_data_i;
`endif
        end else if (state_q != IDLE) begin
            if (!tick) begin
                cnt_q <= cnt_q + DIV_WIDTH'(1);
            end else begin
                cnt_q <= '0;
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        txd_q   <= sh_q[0];
                    end
                    DATA: begin
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= (^data_q) ^ parity_odd_i;
`else
                            state_q <= STOP;
                            stop_q  <= 1'b0;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + BW'(1);
                            txd_q <= sh_q[1];
                            sh_q  <= sh_q >> 1;
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        stop_q  <= 1'b0;
                        txd_q   <= 1'b1;
                    end
                    STOP: begin
                        if (stop_q == STOP_LAST) begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame timing, back-to-back, reset abort, divider capture, two stop bits.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div;
    logic [7:0]  data;
    logic        valid;
    logic        ready, txd, busy, done;
    logic [15:0] div2;
    logic [7:0]  data2;
    logic        valid2;
    logic        ready2, txd2, busy2, done2;
`ifdef UART_TX_PARITY_EN
    logic        podd;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DIV_WIDTH(16), .DATA_WIDTH(8), .STOP_BITS(1)) u_dut (
        .main_clk_i(clk), .main_rst_i(rst), .baud_div_i(div), .tx_data_i(data),
        .tx_valid_i(valid), .tx_ready_o(ready), .txd_o(txd), .busy_o(busy), .done_o(done)
`ifdef UART_TX_PARITY_EN
        , .parity_odd_i(podd)
`endif
    );

    uart_tx_ctrl #(.DIV_WIDTH(16), .DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .main_clk_i(clk), .main_rst_i(rst), .baud_div_i(div2), .tx_data_i(data2),
        .tx_valid_i(valid2), .tx_ready_o(ready2), .txd_o(txd2), .busy_o(busy2), .done_o(done2)
`ifdef UART_TX_PARITY_EN
        , .parity_odd_i(1'b0)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; valid2 = 1'b0; data = '0; data2 = '0; div = '0; div2 = '0;
`ifdef UART_TX_PARITY_EN
        podd = 1'b0;
`endif
        step(); step();
        n_cmp++;
        if ({txd, busy, done} !== 3'b100) begin
            n_bad++; $display("FAIL reset_outputs: got txd/busy/done=%b want 100", {txd, busy, done});
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", ready);
        end
    endtask

    // 0xA5 at div 3: frame bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done at cycle 40.
    task automatic test_frame();
        logic [9:0] exp_bits;
        exp_bits = 10'b11_1010_0101 << 0;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        div = 16'd3; data = 8'hA5; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            n_cmp++;
            if (txd !== exp_bits[(c-1)/4]) begin
                n_bad++; $display("FAIL frame_txd c=%0d: got %b want %b", c, txd, exp_bits[(c-1)/4]);
            end
            n_cmp++;
            if (busy !== 1'b1 || done !== (c == 40)) begin
                n_bad++; $display("FAIL frame_busy_done c=%0d: got %b%b want 1%b", c, busy, done, c == 40);
            end
            step();
        end
        n_cmp++;
        if ({txd, busy, ready} !== 3'b101) begin
            n_bad++; $display("FAIL frame_idle: got txd/busy/ready=%b want 101", {txd, busy, ready});
        end
    endtask

    // Valid held high at div 0: 0x01 then 0xFF with no gap, 20 busy cycles.
    task automatic test_back_to_back();
        logic [19:0] exp_bits;
        exp_bits = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 1'b0};
        div = 16'd0; data = 8'h01; valid = 1'b1;
        step();
        data = 8'hFF;
        for (int c = 1; c <= 20; c++) begin
            n_cmp++;
            if (txd !== exp_bits[c-1] || busy !== 1'b1) begin
                n_bad++; $display("FAIL b2b_txd_busy c=%0d: got %b%b want %b1", c, txd, busy, exp_bits[c-1]);
            end
            n_cmp++;
            if (ready !== (c == 10 || c == 20) || done !== (c == 10 || c == 20)) begin
                n_bad++; $display("FAIL b2b_ready_done c=%0d: got %b%b", c, ready, done);
            end
            if (c == 20) valid = 1'b0;
            step();
        end
        n_cmp++;
        if ({txd, busy} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_end: got txd/busy=%b want 10", {txd, busy});
        end
    endtask

    // Reset during data bit 3 (cycles 17..20 at div 3) truncates the frame.
    task automatic test_reset_midframe();
        div = 16'd3; data = 8'h00; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 1; c < 18; c++) step();
        n_cmp++;
        if ({txd, busy} !== 2'b01) begin
            n_bad++; $display("FAIL rst_mid_pre: got txd/busy=%b want 01", {txd, busy});
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({txd, busy, done} !== 3'b100) begin
            n_bad++; $display("FAIL rst_mid_out: got txd/busy/done=%b want 100", {txd, busy, done});
        end
        rst = 1'b0;
        step();
        for (int c = 0; c < 30; c++) begin
            n_cmp++;
            if ({ready, txd, busy, done} !== 4'b1100) begin
                n_bad++; $display("FAIL rst_mid_after c=%0d: got ready/txd/busy/done=%b want 1100", c, {ready, txd, busy, done});
            end
            step();
        end
    endtask

    // Divider captured at accept: 3 holds for frame one, 9 applies to frame two.
    task automatic test_div_change();
        div = 16'd3; data = 8'h00; valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) div = 16'd9;
            n_cmp++;
            if (done !== (c == 40)) begin
                n_bad++; $display("FAIL div1_done c=%0d: got %b want %b", c, done, c == 40);
            end
            step();
        end
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            n_cmp++;
            if (txd !== (c > 90) || done !== (c == 100)) begin
                n_bad++; $display("FAIL div2_frame c=%0d: got txd/done=%b%b want %b%b", c, txd, done, c > 90, c == 100);
            end
            step();
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL div2_idle: got busy=%b want 0", busy);
        end
    endtask

    // Two stop bits at div 2: stop phase cycles 28..33, done at 33.
    task automatic test_two_stop();
        div2 = 16'd2; data2 = 8'h00; valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            n_cmp++;
            if (txd2 !== (c >= 28) || done2 !== (c == 33) || busy2 !== 1'b1) begin
                n_bad++; $display("FAIL stop2 c=%0d: got txd/done/busy=%b%b%b want %b%b1", c, txd2, done2, busy2, c >= 28, c == 33);
            end
            step();
        end
        n_cmp++;
        if ({txd2, busy2, ready2} !== 3'b101) begin
            n_bad++; $display("FAIL stop2_idle: got txd/busy/ready=%b want 101", {txd2, busy2, ready2});
        end
    endtask

`ifdef UART_TX_PARITY_EN
    // 0x07 at div 1: parity bit at cycles 19..20, 1 for even, 0 for odd.
    task automatic test_parity();
        for (int k = 0; k < 2; k++) begin
            podd = k[0]; div = 16'd1; data = 8'h07; valid = 1'b1;
            step();
            valid = 1'b0;
            for (int c = 1; c <= 22; c++) begin
                if (c == 17 || c == 19 || c == 21) begin
                    n_cmp++;
                    if (txd !== ((c == 19) ? ~k[0] : (c == 21))) begin
                        n_bad++; $display("FAIL parity k=%0d c=%0d: got %b", k, c, txd);
                    end
                end
                n_cmp++;
                if (done !== (c == 22)) begin
                    n_bad++; $display("FAIL parity_done k=%0d c=%0d: got %b", k, c, done);
                end
                step();
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_reset_midframe();
        test_div_change();
        test_two_stop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
